// File: rtl/sec_camo_pkg.sv
// sec_camo_pkg: shared types and elaboration-time helpers for the camouflaged SEC decoder.
// Holds the parity-check column generator, the camouflaged cell positions, the
// key-management state encoding and the camouflaged cell truth function.
package sec_camo_pkg;

  // Key-management states: LOCKED until a key is first shifted in, LOAD while
  // the serial key is being shifted / a commit is waiting, ACTIVE once committed.
  typedef enum logic [1:0] {
    LOCKED = 2'd0,
    LOAD   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  // Positions of the camouflaged correction cells, cell j on data bit KG_POS[j].
  // The table is (13*j) mod 32, a permutation of 0..31, so positions never repeat
  // and cell 0 always lands on data bit 0.
  localparam int KG_POS_N = 32;
  localparam int KG_POS [KG_POS_N] = '{
     0, 13, 26,  7, 20,  1, 14, 27,  8, 21,  2, 15, 28,  9, 22,  3,
    16, 29, 10, 23,  4, 17, 30, 11, 24,  5, 18, 31, 12, 25,  6, 19
  };

  // i-th (0-based) CHK_W-bit value that is neither zero nor a power of two.
  // Powers of two are reserved for single check-bit errors, so every data
  // column is distinct from every check-bit column. Only evaluated at elaboration.
  function automatic logic [31:0] H_COL(input int unsigned i);
    logic [31:0] res;
    int unsigned n;
    res = '0;
    n   = 0;
    for (int unsigned v = 3; v < 4096; v++) begin
      if ((v & (v - 1)) != 0) begin
        if (n == i) res = v;
        n++;
      end
    end
    return res;
  endfunction

  // Index of the camouflaged cell sitting on data bit pos, or -1 for a plain XOR bit.
  function automatic int kg_index(input int pos, input int num_kg);
    int r;
    r = -1;
    for (int j = 0; j < KG_POS_N; j++) begin
      if ((j < num_kg) && (KG_POS[j] == pos) && (r < 0)) r = j;
    end
    return r;
  endfunction

  // Camouflaged cell: XOR when k[0] is set (the only correct behaviour),
  // otherwise NOR for k=2'b10 and NAND for k=2'b00.
  function automatic logic camo(input logic d, input logic c, input logic [1:0] k);
    logic o;
    if (k[0])      o = d ^ c;
    else if (k[1]) o = ~(d | c);
    else           o = ~(d & c);
    return o;
  endfunction

endpackage

// File: rtl/camo_cell2.sv
// camo_cell2: one key-programmable two-input correction cell.
// Replaces the plain correction XOR on a data bit; the function is picked by k.
module camo_cell2
  import sec_camo_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic [1:0] k,
  output logic       o
);

  assign o = camo(a, b, k);

endmodule

// File: rtl/sec_camo_pipe.sv
// sec_camo_pipe: two-stage single-error-correcting decoder whose correction XORs
// on NUM_KG data bits are camouflaged cells programmed by a serially loaded key.
// Stage 1 registers data + syndrome, stage 2 registers the corrected word.
// Optional build macro CAMO_CNT_EN adds err_cnt, a saturating count of errored
// words accepted at the output.
module sec_camo_pipe
  import sec_camo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CHK_W  = 8,
  parameter int NUM_KG = 1
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              key_si,
  input  logic              key_se,
  input  logic              key_commit,
  output logic              key_armed,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CHK_W-1:0]  in_chk,
  input  logic              in_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
`ifdef CAMO_CNT_EN
  ,
  output logic [15:0]       err_cnt
`endif
);

  localparam int KEY_W = 2 * NUM_KG;

  // Key management state
  state_t             state_q, state_d;
  logic [KEY_W-1:0]   key_sr_q, key_sr_d;
  logic [KEY_W-1:0]   key_act_q, key_act_d;
  logic               key_armed_q, key_armed_d;
  logic               commit_pend_q, commit_pend_d;

  // Pipeline state
  logic               s1_v_q;
  logic [DATA_W-1:0]  s1_data_q;
  logic [CHK_W-1:0]   s1_syn_q;
  logic               s2_v_q;
  logic [DATA_W-1:0]  s2_data_q;
  logic               s2_err_q;

  // Combinational datapath
  logic [CHK_W-1:0]   col_term [DATA_W];
  logic [CHK_W-1:0]   syn_d;
  logic [DATA_W-1:0]  flip;
  logic [DATA_W-1:0]  corr_d;

  // Handshake
  logic               s2_adv;
  logic               s1_adv;
  logic               in_fire;
  logic               pipe_empty;

  // A stage may take a new word when it is empty or its content leaves this cycle.
  assign s2_adv     = ~s2_v_q | out_ready;
  assign s1_adv     = ~s1_v_q | s2_adv;
  assign in_ready   = (state_q != LOAD) & (~s1_v_q | ~s2_v_q | out_ready);
  assign in_fire    = in_valid & in_ready;
  assign pipe_empty = ~s1_v_q & ~s2_v_q;

  // Per data bit: parity column, syndrome term, match detect and correction cell.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit
    localparam logic [CHK_W-1:0] HC = CHK_W'(H_COL(gi));
    localparam int               KJ = kg_index(gi, NUM_KG);

    assign col_term[gi] = in_data[gi] ? HC : '0;
    assign flip[gi]     = (s1_syn_q == HC);

    if (KJ >= 0) begin : g_camo
      camo_cell2 u_cell (
        .a (s1_data_q[gi]),
        .b (flip[gi]),
        .k (key_act_q[2*KJ +: 2]),
        .o (corr_d[gi])
      );
    end else begin : g_xor
      assign corr_d[gi] = s1_data_q[gi] ^ flip[gi];
    end
  end

  // Syndrome: masked check bits folded with the columns of every set data bit.
  always_comb begin
    syn_d = in_en ? in_chk : '0;
    for (int i = 0; i < DATA_W; i++) begin
      syn_d = syn_d ^ col_term[i];
    end
  end

  // Stage 1: capture accepted word and its syndrome.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      s1_v_q    <= 1'b0;
      s1_data_q <= '0;
      s1_syn_q  <= '0;
    end else if (s1_adv) begin
      s1_v_q <= in_fire;
      if (in_fire) begin
        s1_data_q <= in_data;
        s1_syn_q  <= syn_d;
      end
    end
  end

  // Stage 2: capture corrected word; holds while the consumer stalls.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      s2_v_q    <= 1'b0;
      s2_data_q <= '0;
      s2_err_q  <= 1'b0;
    end else if (s2_adv) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_data_q <= corr_d;
        s2_err_q  <= |s1_syn_q;
      end
    end
  end

  assign out_valid = s2_v_q;
  assign out_data  = s2_data_q;
  assign out_err   = s2_err_q;
  assign key_armed = key_armed_q;

  // Key FSM next state. Shifting happens on any cycle with key_se. A commit is
  // remembered and only taken in LOAD on a cycle with no shift and an empty
  // pipe, so a word in flight is always corrected with a single key and a
  // commit issued together with a shift sees the post-shift value.
  always_comb begin
    state_d       = state_q;
    key_sr_d      = key_sr_q;
    key_act_d     = key_act_q;
    key_armed_d   = key_armed_q;
    commit_pend_d = commit_pend_q;

    if (key_se) key_sr_d = {key_sr_q[KEY_W-2:0], key_si};
    if (key_commit & ((state_q == LOAD) | key_se)) commit_pend_d = 1'b1;

    case (state_q)
      LOCKED: begin
        if (key_se) state_d = LOAD;
      end
      LOAD: begin
        if (~key_se & (commit_pend_q | key_commit) & pipe_empty) begin
          state_d       = ACTIVE;
          key_act_d     = key_sr_q;
          key_armed_d   = 1'b1;
          commit_pend_d = 1'b0;
        end
      end
      ACTIVE: begin
        if (key_se) state_d = LOAD;
      end
      default: begin
        state_d = LOCKED;
      end
    endcase
  end

  // Key FSM registers.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q       <= LOCKED;
      key_sr_q      <= '0;
      key_act_q     <= '0;
      key_armed_q   <= 1'b0;
      commit_pend_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      key_sr_q      <= key_sr_d;
      key_act_q     <= key_act_d;
      key_armed_q   <= key_armed_d;
      commit_pend_q <= commit_pend_d;
    end
  end

`ifdef CAMO_CNT_EN
  logic [15:0] err_cnt_q;

  // Count errored words delivered to the consumer, sticking at all ones.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      err_cnt_q <= '0;
    end else if (s2_v_q & out_ready & s2_err_q & (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_sec_camo_pipe.sv
// tb_sec_camo_pipe: randomized self-checking bench for sec_camo_pipe with a
// word-level reference model (syndrome by column lookup, one camouflaged bit 0).
`timescale 1ns/1ps
module tb_sec_camo_pipe;

  logic        CK = 1'b0;
  logic        RST;
  logic        key_si, key_se, key_commit, key_armed;
  logic        in_valid, in_ready, in_en;
  logic [31:0] in_data, out_data;
  logic [7:0]  in_chk;
  logic        out_valid, out_ready, out_err;
`ifdef CAMO_CNT_EN
  logic [15:0] err_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  cols [32];
  logic [1:0]  mkey;
  logic [32:0] expq [$];
  int          txn = 0;
  int          ecnt = 0;
  logic        prev_hold = 1'b0;
  logic [32:0] prev_out;

  always #5 CK = ~CK;

  sec_camo_pipe dut (
    .CK         (CK),
    .RST        (RST),
    .key_si     (key_si),
    .key_se     (key_se),
    .key_commit (key_commit),
    .key_armed  (key_armed),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_chk     (in_chk),
    .in_en      (in_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_err    (out_err)
`ifdef CAMO_CNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Syndrome from first principles: check bits (if enabled) xor columns of set data bits.
  function automatic logic [7:0] syn_of(input logic [31:0] d, input logic [7:0] c, input logic en);
    logic [7:0] s;
    s = en ? c : 8'h00;
    for (int i = 0; i < 32; i++) if (d[i]) s ^= cols[i];
    return s;
  endfunction

  // Expected {err, data}: flip the matching bit; bit 0 goes through the keyed cell.
  function automatic logic [32:0] model(input logic [31:0] d, input logic [7:0] c,
                                        input logic en, input logic [1:0] k);
    logic [7:0]  s;
    logic [31:0] o;
    logic        hit;
    s = syn_of(d, c, en);
    o = d;
    for (int i = 1; i < 32; i++) if (s == cols[i]) o[i] = ~d[i];
    hit = (s == cols[0]);
    if (k[0])      o[0] = d[0] ^ hit;
    else if (k[1]) o[0] = ~(d[0] | hit);
    else           o[0] = ~(d[0] & hit);
    return {(s != 8'h00), o};
  endfunction

  // Single compare process: scoreboard on output handshakes, stability while stalled.
  always @(negedge CK) begin
    logic [32:0] e;
    if (RST) begin
      expq.delete();
      prev_hold = 1'b0;
      ecnt      = 0;
    end else begin
      if (prev_hold) check("hold_stable", {out_valid, out_err, out_data}, {1'b1, prev_out});
      if (in_valid && in_ready) expq.push_back(model(in_data, in_chk, in_en, mkey));
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check("out_unexpected", out_valid, 1'b0);
        end else begin
          e = expq.pop_front();
          if (e[32]) ecnt++;
          $display("txn %0d: data=%h err=%b exp_data=%h exp_err=%b", txn, out_data, out_err, e[31:0], e[32]);
          check($sformatf("txn%0d", txn), {out_err, out_data}, e);
          txn++;
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_out  = {out_err, out_data};
    end
  end

  // One word into an idle pipe with out_ready=1, checked at the 2-cycle latency.
  task automatic one_word(input string nm, input logic [31:0] d, input logic [7:0] c,
                          input logic en, input logic [31:0] exp_d, input logic exp_e);
    in_valid = 1'b1; in_data = d; in_chk = c; in_en = en;
    @(negedge CK); check({nm, "_ready"}, in_ready, 1'b1);
    @(posedge CK); #1 in_valid = 1'b0;
    @(negedge CK); check({nm, "_lat1"}, out_valid, 1'b0);
    @(negedge CK); check({nm, "_lat2"}, out_valid, 1'b1);
    check({nm, "_data"}, out_data, exp_d);
    check({nm, "_err"}, out_err, exp_e);
    @(posedge CK); #1;
  endtask

  // Serial key load, MSB first, then commit (optionally together with last shift).
  task automatic load_key(input logic [1:0] k, input logic same_cycle);
    in_valid = 1'b0; out_ready = 1'b1;
    key_se = 1'b1; key_si = k[1];
    @(posedge CK); #1;
    key_si = k[0]; key_commit = same_cycle;
    @(posedge CK); #1;
    key_se = 1'b0; key_si = 1'b0; key_commit = !same_cycle;
    @(posedge CK); #1;
    key_commit = 1'b0;
    repeat (6) @(posedge CK);
    #1;
    mkey = k;
    check("armed_after_reload", key_armed, 1'b1);
  endtask

  task automatic random_phase(input int ncyc);
    logic [31:0] d;
    logic [7:0]  c;
    for (int i = 0; i < ncyc; i++) begin
      d = $urandom;
      c = syn_of(d, 8'h00, 1'b0);
      case ($urandom_range(0, 3))
        0: ;
        1: d = d ^ (32'h1 << $urandom_range(0, 31));
        2: c = c ^ (8'h1 << $urandom_range(0, 7));
        default: c = 8'($urandom);
      endcase
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = d;
      in_chk    = c;
      in_en     = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge CK); #1;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int          acc;
    logic        a;
    logic [31:0] w;
    logic [7:0]  cc;
    int          idx;

    idx = 0;
    for (int v = 3; v < 256; v++) begin
      if (((v & (v - 1)) != 0) && idx < 32) begin
        cols[idx] = 8'(v);
        idx++;
      end
    end

    RST = 1'b1; key_si = 1'b0; key_se = 1'b0; key_commit = 1'b0;
    in_valid = 1'b0; in_data = '0; in_chk = '0; in_en = 1'b1; out_ready = 1'b1;
    mkey = 2'b00;
    repeat (3) @(posedge CK);
    #1 RST = 1'b0;

    // Model pinned by hand: first columns are 3 and 10 at index 5.
    check("col0_literal", cols[0], 8'h03);
    check("col5_literal", cols[5], 8'h0A);

    @(negedge CK);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_err", out_err, 1'b0);
    check("rst_key_armed", key_armed, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge CK); #1;

    // Locked: a clean all-zero word comes out with bit 0 set by the NAND cell.
    one_word("locked_zero", 32'h0, 8'h00, 1'b1, 32'h0000_0001, 1'b0);

    // Stall: out_ready low, three words offered, only two may enter.
    out_ready = 1'b0;
    acc = 0;
    w = $urandom; in_valid = 1'b1; in_data = w; in_chk = syn_of(w, 8'h00, 1'b0); in_en = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge CK); a = in_ready;
      @(posedge CK); #1;
      if (a) begin
        acc++;
        w = $urandom; in_data = w; in_chk = syn_of(w, 8'h00, 1'b0);
      end
    end
    @(negedge CK);
    check("stall_accepted", acc, 2);
    check("stall_in_ready", in_ready, 1'b0);
    check("stall_out_valid", out_valid, 1'b1);
    @(posedge CK); #1 in_valid = 1'b0;

    // Commit with a full pipe must wait for the drain.
    key_se = 1'b1; key_si = 1'b0;
    @(posedge CK); #1 key_si = 1'b1;
    @(posedge CK); #1 key_se = 1'b0; key_si = 1'b0; key_commit = 1'b1;
    @(posedge CK); #1 key_commit = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CK); check("armed_while_full", key_armed, 1'b0);
    end
    @(posedge CK); #1 out_ready = 1'b1;
    a = 1'b0;
    for (int k = 0; k < 10 && !a; k++) begin
      @(negedge CK); a = key_armed;
    end
    check("armed_after_drain", a, 1'b1);
    @(posedge CK); #1 mkey = 2'b01;

    // Correct key: single data error on bit 5 corrected.
    one_word("fix_bit5", 32'h0000_0001, cols[0] ^ cols[5], 1'b1, 32'h0000_0021, 1'b1);
    // Clean word with matching check bits.
    cc = syn_of(32'hA5A5_5A5A, 8'h00, 1'b0);
    one_word("clean", 32'hA5A5_5A5A, cc, 1'b1, 32'hA5A5_5A5A, 1'b0);
    // Check bits masked: syndrome equals the data-only syndrome.
    in_valid = 1'b1; in_data = 32'hA5A5_5A5A; in_chk = cc; in_en = 1'b0;
    @(posedge CK); #1 in_valid = 1'b0;
    @(negedge CK); @(negedge CK);
    check("masked_err", out_err, (cc != 8'h00));
    @(posedge CK); #1;

    random_phase(150);
    load_key(2'b10, 1'b0);
    random_phase(100);
    load_key(2'b11, 1'b1);
    random_phase(100);
    load_key(2'b00, 1'b1);
    random_phase(60);
    load_key(2'b01, 1'b0);
    random_phase(60);

    // Reset mid-stream: output drops at once and the key disarms.
    out_ready = 1'b0; in_valid = 1'b1; w = $urandom;
    in_data = w; in_chk = syn_of(w, 8'h00, 1'b0); in_en = 1'b1;
    repeat (3) @(posedge CK);
    #1 in_valid = 1'b0;
    @(negedge CK); check("pre_rst_valid", out_valid, 1'b1);
    #2 RST = 1'b1;
    #1;
    check("rst_mid_valid", out_valid, 1'b0);
    check("rst_mid_armed", key_armed, 1'b0);
    check("rst_mid_data", out_data, 32'h0);
    @(negedge CK);
    @(posedge CK); #1 RST = 1'b0; mkey = 2'b00; out_ready = 1'b1;

    random_phase(60);

    // Drain everything still expected.
    out_ready = 1'b1;
    for (int k = 0; k < 50 && expq.size() != 0; k++) @(posedge CK);
    @(negedge CK);
    check("drain_empty", expq.size(), 0);
    check("drain_out_valid", out_valid, 1'b0);
`ifdef CAMO_CNT_EN
    check("err_cnt", err_cnt, 64'(ecnt));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
